// File: rtl/l2_port_scheduler.sv
// l2_port_scheduler: lets N_CORES request channels share one L2 port.
// A round-robin search picks one pending request. Its address, write flag
// and write data are captured. The request goes to L2 with a req/ack
// handshake, and the read data returns to the owning core as a one-cycle
// resp_valid pulse.
// Optional build macro: L2_SCHED_TIMEOUT_EN enables an issue/wait watchdog
// that aborts a transaction with resp_err after TIMEOUT cycles.
module l2_port_scheduler #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_CORES-1:0]               req_valid,
  input  logic [N_CORES-1:0]               req_we,
  input  logic [N_CORES-1:0][ADDR_W-1:0]   req_addr,
  input  logic [N_CORES-1:0][DATA_W-1:0]   req_wdata,
  output logic [N_CORES-1:0]               req_ready,
  output logic [N_CORES-1:0]               resp_valid,
  output logic [DATA_W-1:0]                resp_rdata,
  output logic                             resp_err,
  output logic                             l2_req,
  output logic                             l2_we,
  output logic [ADDR_W-1:0]                l2_addr,
  output logic [DATA_W-1:0]                l2_wdata,
  input  logic                             l2_ack,
  input  logic                             l2_done,
  input  logic [DATA_W-1:0]                l2_rdata
);

  localparam int PTR_W = $clog2(N_CORES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PTR_W-1:0]    r_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_found;
  logic [PTR_W-1:0]    w_idx;
  logic [PTR_W-1:0]    w_cand;
  logic                w_accept;
  logic                w_rd_cap;
  logic                w_to_fire;
  logic                w_timeout;

`ifdef L2_SCHED_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;

  // Count the cycles spent in S_ISSUE/S_WAIT. The count restarts at zero
  // for every new transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // The timeout fires on the last allowed cycle. A done that arrives in the
  // same cycle still takes priority.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Error flag of the response being returned. It is cleared by a normal
  // completion and set by an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_rd_cap) begin
      r_err <= 1'b0;
    end else if (w_to_fire) begin
      r_err <= 1'b1;
    end
  end

  assign resp_err = r_err;
`else
  // Without the watchdog the block waits for L2 indefinitely. TIMEOUT is
  // kept so that instantiations stay interchangeable.
  assign w_timeout = 1'b0 && (TIMEOUT > 0);
  assign resp_err  = 1'b0;
`endif

  // Round-robin search that starts at r_ptr and wraps modulo N_CORES.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      w_cand = r_ptr + PTR_W'(i);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the per-state handshake outputs.
  always_comb begin
    w_next     = r_state;
    req_ready  = '0;
    resp_valid = '0;
    l2_req     = 1'b0;
    w_accept   = 1'b0;
    w_rd_cap   = 1'b0;
    w_to_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready[w_idx] = 1'b1;
          w_accept         = 1'b1;
          w_next           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        l2_req = 1'b1;
        if (l2_ack && l2_done) begin
          w_rd_cap = 1'b1;
          w_next   = S_RESP;
        end else if (w_timeout) begin
          w_to_fire = 1'b1;
          w_next    = S_RESP;
        end else if (l2_ack) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (l2_done) begin
          w_rd_cap = 1'b1;
          w_next   = S_RESP;
        end else if (w_timeout) begin
          w_to_fire = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid[r_owner] = 1'b1;
        w_next              = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Capture the accepted request and advance the round-robin pointer past
  // the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_ptr   <= w_idx + 1'b1;
      r_owner <= w_idx;
      r_addr  <= req_addr[w_idx];
      r_we    <= req_we[w_idx];
      r_wdata <= req_wdata[w_idx];
    end
  end

  // Response data register. It holds the L2 read data, or zero after an
  // abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_cap) begin
      r_rdata <= l2_rdata;
    end else if (w_to_fire) begin
      r_rdata <= '0;
    end
  end

  assign l2_we      = r_we;
  assign l2_addr    = r_addr;
  assign l2_wdata   = r_wdata;
  assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Bench for l2_port_scheduler. A transaction-level model runs alongside the
// DUT and is compared on every cycle. Directed scenarios pin the model with
// literal expectations. Random traffic then follows, including stray
// ack/done pulses and occasional resets.
module tb_l2_port_scheduler;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TB_TIMEOUT = 8;
`ifdef L2_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_we = '0;
  logic [N-1:0][AW-1:0]  req_addr = '0;
  logic [N-1:0][DW-1:0]  req_wdata = '0;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          resp_valid;
  logic [DW-1:0]         resp_rdata;
  logic                  resp_err;
  logic                  l2_req;
  logic                  l2_we;
  logic [AW-1:0]         l2_addr;
  logic [DW-1:0]         l2_wdata;
  logic                  l2_ack = 1'b0;
  logic                  l2_done = 1'b0;
  logic [DW-1:0]         l2_rdata = '0;

  int checks = 0;
  int failures = 0;

  l2_port_scheduler #(
    .N_CORES(N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .l2_req    (l2_req),
    .l2_we     (l2_we),
    .l2_addr   (l2_addr),
    .l2_wdata  (l2_wdata),
    .l2_ack    (l2_ack),
    .l2_done   (l2_done),
    .l2_rdata  (l2_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: either no transaction is in flight, or one is
  // in flight. An in-flight transaction is waiting on L2 (acked or not) or
  // is being returned.
  bit                 m_live = 1'b0;
  bit                 m_busy, m_acked, m_resp, m_err;
  int unsigned        m_ptr, m_owner, m_cnt;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata, m_rdata;
  logic               m_we;
  logic [N-1:0]       e_ready, e_resp;
  bit                 fnd;
  int unsigned        idx, jj;

  always @(negedge clk) begin
    fnd = 1'b0;
    idx = 0;
    if (m_live && !m_busy) begin
      for (int unsigned k = 0; k < N; k++) begin
        jj = (m_ptr + k) % N;
        if (!fnd && req_valid[jj]) begin
          fnd = 1'b1;
          idx = jj;
        end
      end
    end
    if (m_live) begin
      e_ready = '0;
      if (fnd) e_ready[idx] = 1'b1;
      chk("m_req_ready", 64'(req_ready), 64'(e_ready));
      chk("m_l2_req", 64'(l2_req), 64'(m_busy && !m_acked && !m_resp));
      if (m_busy && !m_resp) begin
        chk("m_l2_addr", 64'(l2_addr), 64'(m_addr));
        chk("m_l2_we", 64'(l2_we), 64'(m_we));
        chk("m_l2_wdata", 64'(l2_wdata), 64'(m_wdata));
      end
      e_resp = '0;
      if (m_resp) e_resp[m_owner] = 1'b1;
      chk("m_resp_valid", 64'(resp_valid), 64'(e_resp));
      if (m_resp) begin
        chk("m_resp_rdata", 64'(resp_rdata), 64'(m_rdata));
        chk("m_resp_err", 64'(resp_err), 64'(m_err));
      end
    end
    if (rst) begin
      m_live = 1'b1; m_busy = 0; m_acked = 0; m_resp = 0; m_err = 0;
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_rdata = '0;
    end else if (m_live) begin
      if (m_resp) begin
        m_resp = 0;
        m_busy = 0;
      end else if (m_busy) begin
        if ((!m_acked && l2_ack && l2_done) || (m_acked && l2_done)) begin
          m_resp = 1; m_rdata = l2_rdata; m_err = 0;
        end else if (TO_EN && m_cnt == TB_TIMEOUT - 1) begin
          m_resp = 1; m_rdata = '0; m_err = 1;
        end else begin
          if (l2_ack) m_acked = 1;
          m_cnt++;
        end
      end else if (fnd) begin
        m_busy = 1; m_acked = 0; m_cnt = 0;
        m_owner = idx;
        m_ptr = (idx + 1) % N;
        m_addr = req_addr[idx];
        m_we = req_we[idx];
        m_wdata = req_wdata[idx];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    l2_ack = 1'b0; l2_done = 1'b0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_l2_req", 64'(l2_req), 64'h0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'h0);
    chk("rst_resp_err", 64'(resp_err), 64'h0);
    chk("rst_l2_addr", 64'(l2_addr), 64'h0);
    next_cycle();
    rst = 1'b0;
  endtask

  int n_gr, n_rs, k_cyc;

  initial begin
    do_reset();

    // Single read from core 2: ack in cycle 1, done in cycle 3.
    req_valid = 4'b0100; req_addr[2] = 32'h100;
    @(negedge clk); chk("t1_ready", 64'(req_ready), 64'h4);
    next_cycle(); req_valid = '0; l2_ack = 1'b1;
    @(negedge clk); chk("t1_l2_req", 64'(l2_req), 64'h1); chk("t1_l2_addr", 64'(l2_addr), 64'h100);
    next_cycle(); l2_ack = 1'b0;
    @(negedge clk); chk("t1_l2_req_wait", 64'(l2_req), 64'h0);
    next_cycle(); l2_done = 1'b1; l2_rdata = 32'hDEADBEEF;
    @(negedge clk); chk("t1_no_resp_yet", 64'(resp_valid), 64'h0);
    next_cycle(); l2_done = 1'b0;
    @(negedge clk); chk("t1_resp", 64'(resp_valid), 64'h4); chk("t1_rdata", 64'(resp_rdata), 64'hDEADBEEF);
    next_cycle();
    @(negedge clk); chk("t1_resp_once", 64'(resp_valid), 64'h0);

    // All cores hold req_valid and L2 completes at once: grants rotate 0,1,2,3,0.
    do_reset();
    req_valid = 4'b1111; l2_ack = 1'b1; l2_done = 1'b1; l2_rdata = 32'h5A5A;
    n_gr = 0; n_rs = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("t2_order", 64'(req_ready), 64'(1) << (n_gr % N));
        n_gr++;
      end
      if (resp_valid != '0) begin
        chk("t2_resp_owner", 64'(resp_valid), 64'(1) << (n_rs % N));
        n_rs++;
      end
      next_cycle();
    end
    chk("t2_grants", 64'(n_gr), 64'd5);
    chk("t2_resps", 64'(n_rs), 64'd5);
    clear_inputs();

    // Write from core 1 with ack and done in the same cycle.
    do_reset();
    req_valid = 4'b0010; req_we = 4'b0010; req_addr[1] = 32'h40; req_wdata[1] = 32'h1234;
    @(negedge clk); chk("t3_ready", 64'(req_ready), 64'h2);
    next_cycle(); req_valid = '0; l2_ack = 1'b1; l2_done = 1'b1; l2_rdata = 32'h0BAD;
    @(negedge clk);
    chk("t3_l2_req", 64'(l2_req), 64'h1); chk("t3_l2_we", 64'(l2_we), 64'h1);
    chk("t3_l2_wdata", 64'(l2_wdata), 64'h1234); chk("t3_l2_addr", 64'(l2_addr), 64'h40);
    next_cycle(); l2_ack = 1'b0; l2_done = 1'b0;
    @(negedge clk); chk("t3_resp", 64'(resp_valid), 64'h2);

    // Address changes after accept are ignored; a stray done in idle is ignored.
    do_reset();
    req_valid = 4'b0001; req_addr[0] = 32'h10;
    @(negedge clk); chk("t4_ready", 64'(req_ready), 64'h1);
    next_cycle(); req_valid = '0; req_addr[0] = 32'h20;
    @(negedge clk); chk("t4_addr_a", 64'(l2_addr), 64'h10);
    next_cycle();
    @(negedge clk); chk("t4_addr_b", 64'(l2_addr), 64'h10);
    next_cycle(); l2_ack = 1'b1; l2_done = 1'b1; l2_rdata = 32'h77;
    @(negedge clk); chk("t4_addr_c", 64'(l2_addr), 64'h10);
    next_cycle(); l2_ack = 1'b0; l2_done = 1'b0;
    @(negedge clk); chk("t4_resp", 64'(resp_valid), 64'h1);
    next_cycle(); l2_done = 1'b1;
    @(negedge clk); chk("t4_idle_done", 64'(resp_valid), 64'h0);
    next_cycle(); l2_done = 1'b0;
    @(negedge clk); chk("t4_stray_ignored", 64'(resp_valid), 64'h0);

    // Reset while waiting drops the transaction; core 3 is then served normally.
    do_reset();
    req_valid = 4'b1000; req_addr[3] = 32'h300;
    @(negedge clk); chk("t5_ready", 64'(req_ready), 64'h8);
    next_cycle(); req_valid = '0; l2_ack = 1'b1;
    @(negedge clk); chk("t5_l2_req", 64'(l2_req), 64'h1);
    next_cycle(); l2_ack = 1'b0;
    @(negedge clk); chk("t5_wait", 64'(l2_req), 64'h0);
    next_cycle(); rst = 1'b1; l2_done = 1'b1; l2_rdata = 32'h99;
    @(negedge clk);
    next_cycle(); rst = 1'b0; l2_done = 1'b0;
    @(negedge clk); chk("t5_no_resp", 64'(resp_valid), 64'h0); chk("t5_l2_req_low", 64'(l2_req), 64'h0);
    next_cycle(); req_valid = 4'b1000; req_addr[3] = 32'h304;
    @(negedge clk); chk("t5_ready2", 64'(req_ready), 64'h8);
    next_cycle(); req_valid = '0; l2_ack = 1'b1; l2_done = 1'b1; l2_rdata = 32'hCAFE;
    @(negedge clk); chk("t5_addr2", 64'(l2_addr), 64'h304);
    next_cycle(); l2_ack = 1'b0; l2_done = 1'b0;
    @(negedge clk); chk("t5_resp2", 64'(resp_valid), 64'h8); chk("t5_rdata2", 64'(resp_rdata), 64'hCAFE);

`ifdef L2_SCHED_TIMEOUT_EN
    // L2 acks but never completes: abort after TIMEOUT cycles; a late done is ignored.
    do_reset();
    req_valid = 4'b0001; req_addr[0] = 32'h500;
    @(negedge clk); chk("t6_ready", 64'(req_ready), 64'h1);
    k_cyc = 0;
    next_cycle(); req_valid = '0; l2_ack = 1'b1; k_cyc = 1;
    @(negedge clk);
    while (resp_valid == '0 && k_cyc < 20) begin
      next_cycle(); l2_ack = 1'b0; k_cyc++;
      @(negedge clk);
    end
    chk("t6_latency", 64'(k_cyc), 64'(TB_TIMEOUT + 1));
    chk("t6_resp", 64'(resp_valid), 64'h1);
    chk("t6_err", 64'(resp_err), 64'h1);
    chk("t6_rdata", 64'(resp_rdata), 64'h0);
    next_cycle(); l2_done = 1'b1; l2_rdata = 32'h1;
    @(negedge clk); chk("t6_late_done", 64'(resp_valid), 64'h0);
    next_cycle(); l2_done = 1'b0;
    @(negedge clk); chk("t6_late_done2", 64'(resp_valid), 64'h0);
`endif

    // Random traffic checked by the model on every cycle.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      req_valid = N'($urandom);
      req_we    = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
      end
      l2_ack   = ($urandom_range(0, 2) == 0);
      l2_done  = ($urandom_range(0, 2) == 0);
      l2_rdata = $urandom;
      next_cycle();
    end
    rst = 1'b0;
    clear_inputs();
    next_cycle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
